decode_pipe: RTL

- Parametrised, pipelined successor to the single-cycle decode stage.
- Owns the architectural register file, with same-cycle writeback bypass, and a per-register busy scoreboard.
- Stalls on RAW/WAW hazards against in-flight writers.
- Registers decoded operands into a 1-deep ID/EX output stage with valid/ready handshakes on both sides. Sits between fetch (upstream) and execute (downstream).

---
 rtl/decode_pipe.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/decode_pipe.sv
// Pipelined decode stage: register file with writeback bypass, busy
// scoreboard for RAW/WAW stalls, and a 1-deep ID/EX output register.
module decode_pipe #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 3,
    parameter int INSTR_W  = 16,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [REG_AW-1:0] in_src1,
    input  logic              in_src1_use,
    input  logic [REG_AW-1:0] in_src2,
    input  logic              in_src2_use,
    input  logic [REG_AW-1:0] in_dst,
    input  logic              in_dst_en,
    input  logic [1:0]        in_imm_sel,
    input  logic              in_bsel,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_srca,
    output logic [DATA_W-1:0] out_srcb,
    output logic [DATA_W-1:0] out_imm,
    output logic [REG_AW-1:0] out_dst,
    output logic              out_dst_en,
    output logic              err
);

    localparam int NUM_REGS = 2 ** REG_AW;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d, busy_eff;
    logic [NUM_REGS-1:0] wb_mask, set_mask;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_pc_q, out_pc_d;
    logic [DATA_W-1:0] out_srca_q, out_srca_d;
    logic [DATA_W-1:0] out_srcb_q, out_srcb_d;
    logic [DATA_W-1:0] out_imm_q, out_imm_d;
    logic [REG_AW-1:0] out_dst_q, out_dst_d;
    logic              out_dst_en_q, out_dst_en_d;
    logic              err_q, err_d;
    logic              flush_q, flush_d;

    logic              wb_ok, hazard, fire;
    logic [DATA_W-1:0] src1_val, src2_val, imm;
    logic              unused_instr;

    function automatic logic is_zero(input logic [REG_AW-1:0] r);
        return (ZERO_REG != 0) && (r == '0);
    endfunction

    assign unused_instr = ^in_instr;

    always_comb begin
        wb_ok   = wb_en && !is_zero(wb_reg);
        wb_mask = '0;
        if (wb_ok) wb_mask[wb_reg] = 1'b1;
        busy_eff = busy_q & ~wb_mask;
    end

    // Writeback data is forwarded to readers in the same cycle
    always_comb begin
        if (is_zero(in_src1))
            src1_val = '0;
        else if (wb_ok && wb_reg == in_src1)
            src1_val = wb_data;
        else
            src1_val = regs_q[in_src1];
        if (is_zero(in_src2))
            src2_val = '0;
        else if (wb_ok && wb_reg == in_src2)
            src2_val = wb_data;
        else
            src2_val = regs_q[in_src2];
    end

    always_comb begin
        imm = '0;
        unique case (in_imm_sel)
            2'd0: imm = {{(DATA_W-5){in_instr[4]}}, in_instr[4:0]};
            2'd1: imm = {{(DATA_W-5){1'b0}}, in_instr[4:0]};
            2'd2: imm = {{(DATA_W-8){in_instr[7]}}, in_instr[7:0]};
            2'd3: imm = {{(DATA_W-11){in_instr[10]}}, in_instr[10:0]};
            default: imm = '0;
        endcase
    end

    always_comb begin
        hazard = (in_src1_use && busy_eff[in_src1])
              || (in_src2_use && busy_eff[in_src2])
              || (in_dst_en && busy_eff[in_dst]);
        in_ready = !hazard && (!out_valid_q || out_ready) && !flush;
        fire = in_valid && in_ready;
    end

    always_comb begin
        set_mask = '0;
        if (fire && in_dst_en && !is_zero(in_dst))
            set_mask[in_dst] = 1'b1;
        busy_d = flush ? '0 : (busy_eff | set_mask);
        for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
        if (wb_ok) regs_d[wb_reg] = wb_data;
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_srca_d   = out_srca_q;
        out_srcb_d   = out_srcb_q;
        out_imm_d    = out_imm_q;
        out_dst_d    = out_dst_q;
        out_dst_en_d = out_dst_en_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (fire) begin
            out_valid_d  = 1'b1;
            out_pc_d     = in_pc;
            out_srca_d   = src1_val;
            out_srcb_d   = in_bsel ? imm : src2_val;
            out_imm_d    = imm;
            out_dst_d    = in_dst;
            out_dst_en_d = in_dst_en;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Writes to idle registers are tolerated around a flush
    always_comb begin
        flush_d = flush;
        err_d = err_q
             || (wb_ok && !busy_q[wb_reg] && !flush && !flush_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            busy_q       <= '0;
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_srca_q   <= '0;
            out_srcb_q   <= '0;
            out_imm_q    <= '0;
            out_dst_q    <= '0;
            out_dst_en_q <= 1'b0;
            err_q        <= 1'b0;
            flush_q      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
            busy_q       <= busy_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_srca_q   <= out_srca_d;
            out_srcb_q   <= out_srcb_d;
            out_imm_q    <= out_imm_d;
            out_dst_q    <= out_dst_d;
            out_dst_en_q <= out_dst_en_d;
            err_q        <= err_d;
            flush_q      <= flush_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_pc     = out_pc_q;
    assign out_srca   = out_srca_q;
    assign out_srcb   = out_srcb_q;
    assign out_imm    = out_imm_q;
    assign out_dst    = out_dst_q;
    assign out_dst_en = out_dst_en_q;
    assign err        = err_q;

endmodule
